// File: rtl/axi_cfg_regs_gen.sv
// AXI4-Lite config/status slave: CTRL/DEBUG/STATUS, NUM_USER_REGS RW registers and a memory window.
// Optional done/irq logic is enabled by defining AXI_CFG_IRQ_EN.
module axi_cfg_regs_gen #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 16,
  parameter int          NUM_USER_REGS  = 4,
  parameter int unsigned MEM_BASE       = 32'h100,
  parameter int          MEM_ADDR_WIDTH = 12,
  parameter int          MEM_RD_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]         S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]         S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic                          busy,
  output logic [31:0]                   ctrl,
  output logic                          start,
  output logic [31:0]                   debug,
  output logic [32*NUM_USER_REGS-1:0]   user_regs,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic                          mem_wen,
  output logic [3:0]                    mem_wstrb,
  output logic [31:0]                   mem_data_in,
  output logic                          mem_ren,
  input  logic [31:0]                   mem_data_out,
  output logic                          irq
);

  // state | meaning
  // IDLE  | waiting for AW (priority) or AR
  // WR_ACC| collecting AW and W handshakes, then commit
  // WR_RESP| BVALID held until BREADY
  // RD_WAIT| AR handshake, register/memory read latency
  // RD_RESP| RVALID/RDATA held until RREADY
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ACC  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam int unsigned MEM_SPAN    = 32'd4 << MEM_ADDR_WIDTH;

`ifdef AXI_CFG_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic [2:0]                state_q, state_d;
  logic                      awready_q, wready_q, aw_got_q, w_got_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  logic                      arready_q, ar_got_q;
  logic [1:0]                rd_cnt_q;
  logic                      rvalid_q;
  logic [31:0]               rdata_q;
  logic [1:0]                rresp_q;
  logic [31:0]               ctrl_q, debug_q;
  logic [31:0]               user_q [NUM_USER_REGS];
  logic                      start_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic                      mem_wen_q, mem_ren_q;
  logic [3:0]                mem_wstrb_q;
  logic [31:0]               mem_wdata_q;
  logic                      done_sticky;

  logic [29:0] addr_w;
  logic        mem_hit, reg_err, wr_err, wr_go, rd_go;
  logic [31:0] reg_rdata;

  function automatic logic is_mem(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] ab;
    ab = 32'(a);
    return (ab >= MEM_BASE) && ((ab - MEM_BASE) < MEM_SPAN);
  endfunction

  function automatic logic [MEM_ADDR_WIDTH-1:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
    return MEM_ADDR_WIDTH'((32'(a) - MEM_BASE) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  assign addr_w  = 30'(addr_q >> 2);
  assign mem_hit = is_mem(addr_q);
  assign wr_go   = (state_q == S_WR_ACC) && aw_got_q && w_got_q;
  assign rd_go   = (state_q == S_RD_WAIT) && ar_got_q && (rd_cnt_q == 2'd0);
  assign wr_err  = reg_err || ((addr_w == 30'd2) && !IRQ_EN);

  // CTRL bit1 reads back the live busy input rather than the stored bit.
  always_comb begin
    reg_rdata = '0;
    reg_err   = 1'b0;
    case (addr_w)
      30'd0:   reg_rdata = {ctrl_q[31:2], busy, ctrl_q[0]};
      30'd1:   reg_rdata = debug_q;
      30'd2:   reg_rdata = {30'd0, done_sticky, busy};
      default: reg_err = 1'b1;
    endcase
    for (int i = 0; i < NUM_USER_REGS; i++) begin
      if (addr_w == 30'(4 + i)) begin
        reg_rdata = user_q[i];
        reg_err   = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (S_AXI_AWVALID)      state_d = S_WR_ACC;
        else if (S_AXI_ARVALID) state_d = S_RD_WAIT;
      end
      S_WR_ACC:  if (wr_go)          state_d = S_WR_RESP;
      S_WR_RESP: if (S_AXI_BREADY)   state_d = S_IDLE;
      S_RD_WAIT: if (rd_go)          state_d = S_RD_RESP;
      S_RD_RESP: if (S_AXI_RREADY)   state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      arready_q   <= 1'b0;
      ar_got_q    <= 1'b0;
      rd_cnt_q    <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      ctrl_q      <= '0;
      debug_q     <= '0;
      for (int i = 0; i < NUM_USER_REGS; i++) user_q[i] <= '0;
      start_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= 1'b0;
      ctrl_q[0] <= 1'b0;
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;

      if (state_q == S_WR_ACC) begin
        if (awready_q) begin
          if (S_AXI_AWVALID) begin
            awready_q <= 1'b0;
            aw_got_q  <= 1'b1;
            addr_q    <= S_AXI_AWADDR;
          end
        end else if (!aw_got_q && S_AXI_AWVALID) begin
          awready_q <= 1'b1;
        end
        if (wready_q) begin
          if (S_AXI_WVALID) begin
            wready_q <= 1'b0;
            w_got_q  <= 1'b1;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
          end
        end else if (!w_got_q && S_AXI_WVALID) begin
          wready_q <= 1'b1;
        end
      end

      if (wr_go) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bvalid_q <= 1'b1;
        if (mem_hit) begin
          bresp_q     <= RESP_OKAY;
          mem_wen_q   <= |wstrb_q;
          mem_addr_q  <= mem_word(addr_q);
          mem_wstrb_q <= wstrb_q;
          mem_wdata_q <= wdata_q;
        end else if (wr_err) begin
          bresp_q <= RESP_SLVERR;
        end else begin
          bresp_q <= RESP_OKAY;
          case (addr_w)
            30'd0: begin
              ctrl_q  <= merge(ctrl_q, wdata_q, wstrb_q);
              start_q <= wstrb_q[0] & wdata_q[0];
            end
            30'd1:   debug_q <= merge(debug_q, wdata_q, wstrb_q);
            default: ;
          endcase
          for (int i = 0; i < NUM_USER_REGS; i++)
            if (addr_w == 30'(4 + i)) user_q[i] <= merge(user_q[i], wdata_q, wstrb_q);
        end
      end

      if ((state_q == S_WR_RESP) && S_AXI_BREADY) bvalid_q <= 1'b0;

      if ((state_q == S_IDLE) && (state_d == S_RD_WAIT)) arready_q <= 1'b1;

      if (state_q == S_RD_WAIT) begin
        if (arready_q) begin
          if (S_AXI_ARVALID) begin
            arready_q <= 1'b0;
            ar_got_q  <= 1'b1;
            addr_q    <= S_AXI_ARADDR;
            if (is_mem(S_AXI_ARADDR)) begin
              mem_ren_q  <= 1'b1;
              mem_addr_q <= mem_word(S_AXI_ARADDR);
              rd_cnt_q   <= 2'(MEM_RD_LAT);
            end else begin
              rd_cnt_q   <= 2'd0;
            end
          end
        end else if (ar_got_q) begin
          if (rd_cnt_q == 2'd0) begin
            ar_got_q <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= mem_hit ? mem_data_out : (reg_err ? 32'd0 : reg_rdata);
            rresp_q  <= (mem_hit || !reg_err) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rd_cnt_q <= rd_cnt_q - 2'd1;
          end
        end
      end

      if ((state_q == S_RD_RESP) && S_AXI_RREADY) rvalid_q <= 1'b0;
    end
  end

`ifdef AXI_CFG_IRQ_EN
  logic busy_q, done_q, irq_q, status_clr;

  assign status_clr = wr_go && !mem_hit && (addr_w == 30'd2) && wstrb_q[0] && wdata_q[1];

  // A busy falling edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      busy_q <= busy;
      done_q <= (busy_q & ~busy) | (done_q & ~status_clr);
      irq_q  <= done_q & ctrl_q[2];
    end
  end

  assign done_sticky = done_q;
  assign irq         = irq_q;
`else
  assign done_sticky = 1'b0;
  assign irq         = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_USER_REGS; gi++) begin : g_user
    assign user_regs[32*gi +: 32] = user_q[gi];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl          = ctrl_q;
  assign start         = start_q;
  assign debug         = debug_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_ren       = mem_ren_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign mem_data_in   = mem_wdata_q;

endmodule
